// File: rtl/interval_meter.sv
// Measures ms between successive rising edges of Event using a cycle prescaler.
// Latency: Value/Overflow/Valid registered at the posedge that samples the capturing edge.
// Backpressure: none; Valid is a one-cycle strobe and Value holds until the next capture.
module interval_meter #(
    parameter int MS_CYCLES = 50000,
    parameter int WIDTH     = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Clear,
    input  logic             Event,
    output logic [WIDTH-1:0] Value,
    output logic             Valid,
    output logic             Overflow,
    output logic             Busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int              PW       = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(MS_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic             r_evq;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] r_value;
    logic             r_valid;
    logic             r_overflow;

    logic             w_rise;
    logic             w_wrap;
    logic             w_cnt_max;

    assign w_rise    = Event & ~r_evq & Enable;
    assign w_wrap    = (r_pre == PRE_LAST);
    assign w_cnt_max = (r_cnt == CNT_MAX);

    // evq resets high so a level already present at reset release is not an edge.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_evq      <= 1'b1;
            r_pre      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_value    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_evq   <= Event;
            r_valid <= 1'b0;
            if (Clear) begin
                r_state <= S_IDLE;
                r_pre   <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_pre <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                        if (w_rise) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_rise) begin
                            // A wrap coinciding with the capture still counts as a finished ms.
                            r_value    <= (w_wrap && !w_cnt_max) ? r_cnt + 1'b1 : r_cnt;
                            r_overflow <= r_ovf | (w_wrap & w_cnt_max);
                            r_valid    <= 1'b1;
                            r_pre      <= '0;
                            r_cnt      <= '0;
                            r_ovf      <= 1'b0;
                        end else if (Enable) begin
                            if (w_wrap) begin
                                r_pre <= '0;
                                if (w_cnt_max) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end else begin
                                r_pre <= r_pre + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign Value    = r_value;
    assign Valid    = r_valid;
    assign Overflow = r_overflow;
    assign Busy     = (r_state == S_RUN);

endmodule

// File: tb/tb_interval_meter.sv
// Drives two interval_meter instances (MS=4/W=10 and MS=2/W=4) with shared stimulus
// and compares them every cycle against an interval-length model.
module tb_interval_meter;

    logic       Clk;
    logic       Rst;
    logic       Enable;
    logic       Clear;
    logic       Event;
    logic [9:0] val0;
    logic       vld0, ovf0, busy0;
    logic [3:0] val1;
    logic       vld1, ovf1, busy1;

    int tests = 0;
    int fails = 0;

    interval_meter #(.MS_CYCLES(4), .WIDTH(10)) u_ms4 (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Clear(Clear), .Event(Event),
        .Value(val0), .Valid(vld0), .Overflow(ovf0), .Busy(busy0)
    );

    interval_meter #(.MS_CYCLES(2), .WIDTH(4)) u_sat (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Clear(Clear), .Event(Event),
        .Value(val1), .Valid(vld1), .Overflow(ovf1), .Busy(busy1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Model: count enabled cycles since the starting edge, divide by MS on capture.
    int ms_c [2] = '{4, 2};
    int wd   [2] = '{10, 4};
    bit run_m[2];
    int n_m  [2];
    int val_m[2];
    bit ovf_m[2];
    bit vld_m[2];
    bit evq_m;

    task automatic model_rst();
        evq_m = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_m[i] = 0; n_m[i] = 0; val_m[i] = 0; ovf_m[i] = 0; vld_m[i] = 0;
        end
    endtask

    task automatic model_update(input bit ev, input bit en, input bit clr);
        bit rise;
        int q, mx;
        rise  = ev && !evq_m && en;
        evq_m = ev;
        for (int i = 0; i < 2; i++) begin
            vld_m[i] = 0;
            if (clr) begin
                run_m[i] = 0;
                n_m[i]   = 0;
            end else if (rise) begin
                if (run_m[i]) begin
                    q  = (n_m[i] + 1) / ms_c[i];
                    mx = (1 << wd[i]) - 1;
                    val_m[i] = (q > mx) ? mx : q;
                    ovf_m[i] = (q > mx);
                    vld_m[i] = 1;
                end
                run_m[i] = 1;
                n_m[i]   = 0;
            end else if (run_m[i] && en) begin
                n_m[i]++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ms4_valid",    32'(vld0),  32'(vld_m[0]));
        chk("ms4_value",    32'(val0),  val_m[0]);
        chk("ms4_overflow", 32'(ovf0),  32'(ovf_m[0]));
        chk("ms4_busy",     32'(busy0), 32'(run_m[0]));
        chk("sat_valid",    32'(vld1),  32'(vld_m[1]));
        chk("sat_value",    32'(val1),  val_m[1]);
        chk("sat_overflow", 32'(ovf1),  32'(ovf_m[1]));
        chk("sat_busy",     32'(busy1), 32'(run_m[1]));
    endtask

    task automatic step(input bit ev, input bit en, input bit clr);
        Event  = ev;
        Enable = en;
        Clear  = clr;
        @(posedge Clk);
        model_update(ev, en, clr);
        #1;
        check_all();
    endtask

    // Assumes the previous step was a rise; the next rise lands g cycles later.
    task automatic gap(input int g);
        repeat (g - 1) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ms4_value"}, 32'(val0), 0);
        chk({tag, "_ms4_valid"}, 32'(vld0), 0);
        chk({tag, "_ms4_ovf"},   32'(ovf0), 0);
        chk({tag, "_ms4_busy"},  32'(busy0), 0);
        chk({tag, "_sat_value"}, 32'(val1), 0);
        chk({tag, "_sat_busy"},  32'(busy1), 0);
    endtask

    bit cur_ev;
    bit r_en;
    bit r_clr;

    initial begin
        Rst = 1'b0; Event = 1'b0; Enable = 1'b1; Clear = 1'b0;
        model_rst();
        #3;
        chk_reset_outputs("reset");
        #9;
        Rst = 1'b1;

        // First edge at cycle 5, second 10 cycles later.
        repeat (4) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("first_edge_valid", 32'(vld0), 0);
        chk("first_edge_busy",  32'(busy0), 1);
        gap(10);
        chk("gap10_value", 32'(val0), 2);
        chk("gap10_valid", 32'(vld0), 1);
        chk("gap10_ovf",   32'(ovf0), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("valid_one_cycle", 32'(vld0), 0);
        step(1'b1, 1'b1, 1'b0);

        // Prescaler wrap coinciding with the capture.
        gap(8);  chk("gap8_value", 32'(val0), 2);
        gap(7);  chk("gap7_value", 32'(val0), 1);
        gap(2);  chk("gap2a_value", 32'(val0), 0); chk("gap2a_valid", 32'(vld0), 1);
        gap(2);  chk("gap2b_value", 32'(val0), 0); chk("gap2b_valid", 32'(vld0), 1);

        // Saturation on the 4-bit instance.
        gap(30); chk("sat30_value", 32'(val1), 15); chk("sat30_ovf", 32'(ovf1), 0);
        gap(31); chk("sat31_value", 32'(val1), 15); chk("sat31_ovf", 32'(ovf1), 0);
        gap(40); chk("sat40_value", 32'(val1), 15); chk("sat40_ovf", 32'(ovf1), 1);
        gap(6);  chk("sat6_value",  32'(val1), 3);  chk("sat6_ovf",  32'(ovf1), 0);

        // 12 enabled cycles with a 20-cycle pause in the middle.
        repeat (5)  step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        repeat (6)  step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("pause_value", 32'(val0), 3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("disabled_rise_valid", 32'(vld0), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("reenable_high_valid", 32'(vld0), 0);
        step(1'b0, 1'b1, 1'b0);

        // Clear coinciding with a rise.
        step(1'b1, 1'b1, 1'b1);
        chk("clear_rise_valid", 32'(vld0), 0);
        chk("clear_rise_busy",  32'(busy0), 0);
        chk("clear_rise_value", 32'(val0), 3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("restart_valid", 32'(vld0), 0);
        chk("restart_busy",  32'(busy0), 1);
        gap(4);
        chk("restart_value", 32'(val0), 1);

        // Async reset between edges with Event held high across release.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        Event = 1'b1;
        #2;
        Rst = 1'b0;
        #1;
        model_rst();
        chk_reset_outputs("async");
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("post_reset_busy", 32'(busy0), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("fresh_edge_busy",  32'(busy0), 1);
        chk("fresh_edge_valid", 32'(vld0), 0);

        // Randomised traffic against the model.
        cur_ev = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 99) < 12) cur_ev = ~cur_ev;
            r_en  = ($urandom_range(0, 9) != 0);
            r_clr = ($urandom_range(0, 199) == 0);
            step(cur_ev, r_en, r_clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
